// File: rtl/uart_tx_ctrl_if.sv
// Handshake and tx_mux-facing signal bundle for the UART transmit sequencer.
// The master side is the byte source (and any observer of the mux controls).
// The slave side is the sequencer itself.
interface uart_tx_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  tx_start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_ready;
    logic                  busy;
    logic                  tx_done;
    logic [1:0]            select;
    logic                  data_bit;
    logic                  parity_bit;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_ready,
        input  busy,
        input  tx_done,
        input  select,
        input  data_bit,
        input  parity_bit
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_ready,
        output busy,
        output tx_done,
        output select,
        output data_bit,
        output parity_bit
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a parallel word over a ready/start
// handshake and steps tx_mux through start, data (LSB first), optional
// parity and stop bit periods, each CLKS_PER_BIT clocks long.
// tx_mux select encoding: 00 start, 01 data, 10 parity, 11 stop/idle.
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      baud_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_q;
    logic                  done_q;
    logic                  ready_q;
    logic                  busy_q;
    logic [1:0]            select_q;
    logic [1:0]            select_d;
    logic                  bit_end;
    logic                  accept;
    logic                  last_bit;

    assign bit_end  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign accept   = (state_q == IDLE) && bus.tx_start;
    assign last_bit = (bit_idx == IDX_W'(DATA_WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing and the mux select for the state being entered.
    always_comb begin
        state_d  = state_q;
        select_d = SEL_STOP;
        case (state_q)
            IDLE:    if (bus.tx_start) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && last_bit) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        case (state_d)
            START:   select_d = SEL_START;
            DATA:    select_d = SEL_DATA;
            PARITY:  select_d = SEL_PARITY;
            default: select_d = SEL_STOP;
        endcase
    end

    // Output registers, loaded from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            select_q <= SEL_STOP;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            select_q <= select_d;
            ready_q  <= (state_d == IDLE);
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_q == STOP) && bit_end;
        end
    end

    // Baud timing, bit index, data shifter and parity capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            parity_q  <= 1'b0;
        end else if (accept) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= bus.tx_data;
            parity_q  <= (^bus.tx_data) ^ PARITY_ODD[0];
        end else if (state_q != IDLE) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (state_q == DATA) begin
                    shift_reg <= shift_reg >> 1;
                    bit_idx   <= bit_idx + 1'b1;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    assign bus.select     = select_q;
    assign bus.tx_ready   = ready_q;
    assign bus.busy       = busy_q;
    assign bus.tx_done    = done_q;
    assign bus.data_bit   = shift_reg[0];
    assign bus.parity_bit = parity_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three instances at CLKS_PER_BIT=4 cover even
// parity, odd parity and no parity. Expected frames are queued when a word
// is offered and compared when the monitor sees tx_done.
module tb_uart_tx_ctrl;

    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) if_a ();
    uart_tx_ctrl_if #(.DATA_WIDTH(8)) if_b ();
    uart_tx_ctrl_if #(.DATA_WIDTH(8)) if_c ();

    uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    logic       st  [3];
    logic [7:0] dat [3];
    logic [1:0] sel [3];
    logic       db  [3];
    logic       pb  [3];
    logic       dn  [3];
    logic       rdy [3];
    logic       by  [3];

    assign if_a.tx_start = st[0];
    assign if_b.tx_start = st[1];
    assign if_c.tx_start = st[2];
    assign if_a.tx_data  = dat[0];
    assign if_b.tx_data  = dat[1];
    assign if_c.tx_data  = dat[2];

    assign sel[0] = if_a.select;     assign sel[1] = if_b.select;     assign sel[2] = if_c.select;
    assign db[0]  = if_a.data_bit;   assign db[1]  = if_b.data_bit;   assign db[2]  = if_c.data_bit;
    assign pb[0]  = if_a.parity_bit; assign pb[1]  = if_b.parity_bit; assign pb[2]  = if_c.parity_bit;
    assign dn[0]  = if_a.tx_done;    assign dn[1]  = if_b.tx_done;    assign dn[2]  = if_c.tx_done;
    assign rdy[0] = if_a.tx_ready;   assign rdy[1] = if_b.tx_ready;   assign rdy[2] = if_c.tx_ready;
    assign by[0]  = if_a.busy;       assign by[1]  = if_b.busy;       assign by[2]  = if_c.busy;

    typedef struct {
        int unsigned dut;
        logic [7:0]  data;
        logic        par;
        int unsigned len;
        int          gap;   // required idle gap before this frame, -1 = don't care
    } exp_t;

    exp_t        exp_q[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc = 0;

    bit          in_frame [3];
    int unsigned kk       [3];
    logic [7:0]  obs_d    [3];
    logic        obs_p    [3];
    int unsigned sel_err  [3];
    bit          par_seen [3];
    int unsigned start_cyc[3];
    int unsigned done_cyc [3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit pen_of(input int unsigned i);
        return i != 2;
    endfunction

    function automatic bit odd_of(input int unsigned i);
        return i == 1;
    endfunction

    function automatic int unsigned len_of(input int unsigned i);
        return (2 + 8 + (pen_of(i) ? 1 : 0)) * CPB;
    endfunction

    // Required select for cycle k of a frame (k=0 is the first START cycle).
    function automatic logic [1:0] exp_sel(input int unsigned i, input int unsigned k);
        if (k < CPB) return 2'b00;
        if (k < 9 * CPB) return 2'b01;
        if (pen_of(i) && k < 10 * CPB) return 2'b10;
        return 2'b11;
    endfunction

    task automatic finish_frame(input int unsigned i);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_frame", 32'(i), 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check_eq("frame_dut", 32'(i), 32'(e.dut));
            check_eq("data_bits", 32'(obs_d[i]), 32'(e.data));
            check_eq("parity_bit", 32'(obs_p[i]), 32'(e.par));
            check_eq("frame_len", 32'(kk[i]), 32'(e.len));
            check_eq("select_seq_errs", 32'(sel_err[i]), 32'd0);
            check_eq("parity_slot_seen", 32'(par_seen[i]), 32'(pen_of(i)));
            if (e.gap >= 0)
                check_eq("idle_gap", 32'(start_cyc[i] - done_cyc[i]), 32'(e.gap));
        end
    endtask

    // Frame monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                in_frame[i] = 1'b0;
            end else begin
                if (!in_frame[i] && by[i]) begin
                    in_frame[i]  = 1'b1;
                    kk[i]        = 0;
                    obs_d[i]     = '0;
                    obs_p[i]     = 1'b0;
                    sel_err[i]   = 0;
                    par_seen[i]  = 1'b0;
                    start_cyc[i] = cyc;
                end
                if (in_frame[i]) begin
                    if (sel[i] !== exp_sel(i, kk[i])) sel_err[i]++;
                    if (sel[i] == 2'b10) par_seen[i] = 1'b1;
                    if (kk[i] >= CPB && kk[i] < 9 * CPB && (kk[i] % CPB) == CPB / 2)
                        obs_d[i][(kk[i] - CPB) / CPB] = db[i];
                    if (kk[i] == 1) obs_p[i] = pb[i];
                    if (dn[i]) begin
                        finish_frame(i);
                        in_frame[i] = 1'b0;
                        done_cyc[i] = cyc;
                    end else if (kk[i] > 15 * CPB) begin
                        check_eq("frame_timeout", 32'(kk[i]), 32'(len_of(i)));
                        in_frame[i] = 1'b0;
                    end
                    kk[i]++;
                end else if (dn[i]) begin
                    check_eq("spurious_done", 32'(i), 32'hFFFF_FFFF);
                end
            end
        end
    end

    task automatic push_exp(input int unsigned i, input logic [7:0] d, input int gap);
        exp_t e;
        e.dut  = i;
        e.data = d;
        e.par  = (^d) ^ odd_of(i);
        e.len  = len_of(i);
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic send(input int unsigned i, input logic [7:0] d, input bit expect_it);
        int unsigned n = 0;
        while (!rdy[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("ready_timeout", 32'(n), 32'd0);
        st[i]  = 1'b1;
        dat[i] = d;
        if (expect_it) push_exp(i, d, -1);
        @(posedge clk);
        #1;
        st[i] = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int unsigned n;
        for (int i = 0; i < 3; i++) begin
            st[i]  = 1'b0;
            dat[i] = '0;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst_select", 32'(sel[0]), 32'd3);
        check_eq("rst_ready", 32'(rdy[0]), 32'd1);
        check_eq("rst_busy", 32'(by[0]), 32'd0);
        check_eq("rst_done", 32'(dn[0]), 32'd0);
        check_eq("rst_parity", 32'(pb[0]), 32'd0);
        check_eq("rst_data_bit", 32'(db[0]), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, even parity.
        send(0, 8'hA5, 1'b1);
        wait_drain();

        // Parity variants on 8'h07.
        send(0, 8'h07, 1'b1);
        wait_drain();
        send(1, 8'h07, 1'b1);
        wait_drain();
        send(2, 8'h07, 1'b1);
        wait_drain();

        // Start request while busy is ignored.
        send(0, 8'h3C, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        st[0]  = 1'b1;
        dat[0] = 8'hFF;
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        wait_drain();
        repeat (60) @(negedge clk);

        // Back-to-back frames with tx_start held.
        @(negedge clk);
        st[0]  = 1'b1;
        dat[0] = 8'h55;
        push_exp(0, 8'h55, -1);
        @(posedge clk);
        #1;
        dat[0] = 8'hAA;
        push_exp(0, 8'hAA, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dn[0] && n < 100);
        if (n >= 100) check_eq("b2b_done_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        wait_drain();

        // Asynchronous reset during the parity period.
        send(0, 8'hF0, 1'b0);
        n = 0;
        while (sel[0] != 2'b10 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("parity_state_timeout", 32'(n), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_select", 32'(sel[0]), 32'd3);
        check_eq("async_rst_ready", 32'(rdy[0]), 32'd1);
        check_eq("async_rst_busy", 32'(by[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);

        // Recovery frame after the abandoned one.
        send(0, 8'h01, 1'b1);
        wait_drain();

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
